// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
//   FWD_*        operand-select encodings driven on ForwardAE/ForwardBE
//   RESULT_LOAD  ResultSrcE value that marks a load in Execute
//   mul_state_e  multi-cycle execute FSM states
package hazard_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_forward_sel.sv
// Forwarding select for one Execute operand.
//   rs            source register of the operand in Execute
//   rd_m/rd_w     Memory/Writeback destination registers
//   reg_write_*   write enables of those stages
//   fwd_c         combinational select: MEM beats WB, x0 never forwarded
module forward_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output logic [1:0]        fwd_c
);

    // Priority compare; the youngest producer (Memory) wins.
    always_comb begin
        fwd_c = FWD_RF;
        if (rs != '0) begin
            if (reg_write_m && (rd_m == rs)) begin
                fwd_c = FWD_MEM;
            end else if (reg_write_w && (rd_w == rs)) begin
                fwd_c = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage core.
//   Inputs : Decode/Execute/Memory/Writeback register addresses and write
//            enables, ResultSrcE, MultiE (multi-cycle op), PCSrcE (taken
//            branch), clk, rst (async active-low).
//   Outputs: ForwardAE/BE operand selects, StallF/D/E, FlushD/E/M, BusyE
//            (all combinational, forced to 0 while in reset), StallCnt and
//            FlushCnt free-running performance counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [1:0]        ResultSrcE,
    input  logic              MultiE,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RD_M,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RD_W,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              BusyE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    // Down-counter must hold MUL_LAT-2; keep at least one bit when MUL_LAT==1.
    localparam int unsigned CNT_BITS = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam bit          MULTI    = (MUL_LAT > 1);

    mul_state_e          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                mul_stall;
    logic                busy;
    logic                lw_stall;
    logic                stall_fd;
    logic                flush_e;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;

    forward_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (Rs1_E),
        .rd_m        (RD_M),
        .reg_write_m (RegWriteM),
        .rd_w        (RD_W),
        .reg_write_w (RegWriteW),
        .fwd_c       (fwd_a)
    );

    forward_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (Rs2_E),
        .rd_m        (RD_M),
        .reg_write_m (RegWriteM),
        .rd_w        (RD_W),
        .reg_write_w (RegWriteW),
        .fwd_c       (fwd_b)
    );

    // Multi-cycle FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multi-cycle FSM next state; the op leaves Execute on the cnt==0 BUSY cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_stall = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (MultiE && MULTI) begin
                    mul_stall = 1'b1;
                    busy      = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = CNT_BITS'(MUL_LAT - 2);
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt_q != '0) begin
                    mul_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_BITS'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hazard equations: a taken branch overrides stalls, a held multi-cycle op is never flushed.
    always_comb begin
        lw_stall = (ResultSrcE == RESULT_LOAD) && (RD_E != '0) &&
                   ((RD_E == Rs1_D) || (RD_E == Rs2_D));
        stall_fd = (lw_stall || mul_stall) && !PCSrcE;
        flush_e  = (lw_stall || PCSrcE) && !mul_stall;
    end

    // Outputs read 0 for as long as reset is held.
    assign ForwardAE = rst ? fwd_a : FWD_RF;
    assign ForwardBE = rst ? fwd_b : FWD_RF;
    assign StallF    = rst & stall_fd;
    assign StallD    = rst & stall_fd;
    assign StallE    = rst & mul_stall;
    assign FlushM    = rst & mul_stall;
    assign FlushD    = rst & PCSrcE;
    assign FlushE    = rst & flush_e;
    assign BusyE     = rst & busy;

    // Performance counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (stall_fd) StallCnt <= StallCnt + CNT_W'(1);
            if (flush_e)  FlushCnt <= FlushCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: MUL_LAT=3 and MUL_LAT=1 instances share stimulus
// and are checked each cycle against a cycle-occupancy reference model.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
    logic [1:0] ResultSrcE;
    logic       MultiE, PCSrcE, RegWriteM, RegWriteW;

    logic [1:0]  fa [2];
    logic [1:0]  fb [2];
    logic        sf [2];
    logic        sd [2];
    logic        se [2];
    logic        fd [2];
    logic        fe [2];
    logic        fm [2];
    logic        be [2];
    logic [31:0] sc [2];
    logic [31:0] fc [2];

    int total = 0;
    int bad   = 0;

    // Reference model: cycles the current multi-cycle op has spent in Execute.
    int          lat   [2] = '{3, 1};
    int          phase [2] = '{0, 0};
    logic [31:0] m_sc  [2] = '{32'd0, 32'd0};
    logic [31:0] m_fc  [2] = '{32'd0, 32'd0};
    int          stall_obs0 = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .MUL_LAT(3), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E),
        .Rs2_E(Rs2_E), .RD_E(RD_E), .ResultSrcE(ResultSrcE), .MultiE(MultiE),
        .PCSrcE(PCSrcE), .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W),
        .RegWriteW(RegWriteW), .ForwardAE(fa[0]), .ForwardBE(fb[0]),
        .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]), .FlushD(fd[0]),
        .FlushE(fe[0]), .FlushM(fm[0]), .BusyE(be[0]), .StallCnt(sc[0]),
        .FlushCnt(fc[0])
    );

    hazard_ctrl_unit #(.REG_AW(5), .MUL_LAT(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E),
        .Rs2_E(Rs2_E), .RD_E(RD_E), .ResultSrcE(ResultSrcE), .MultiE(MultiE),
        .PCSrcE(PCSrcE), .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W),
        .RegWriteW(RegWriteW), .ForwardAE(fa[1]), .ForwardBE(fb[1]),
        .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]), .FlushD(fd[1]),
        .FlushE(fe[1]), .FlushM(fm[1]), .BusyE(be[1]), .StallCnt(sc[1]),
        .FlushCnt(fc[1])
    );

    task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (RegWriteM && RD_M == rs) return 2'b10;
        if (RegWriteW && RD_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Inputs are already applied (at a falling edge); check, then advance the model.
    task automatic cycle();
        bit lw, ms, busy, sfd, fle;
        #1;
        lw = (ResultSrcE == 2'b01) && (RD_E != 5'd0) && (RD_E == Rs1_D || RD_E == Rs2_D);
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                phase[i] = 0;
                m_sc[i]  = 32'd0;
                m_fc[i]  = 32'd0;
            end
            if (phase[i] == 0) begin
                ms   = MultiE && (lat[i] > 1);
                busy = ms;
            end else begin
                busy = 1'b1;
                ms   = (phase[i] < lat[i] - 1);
            end
            sfd = (lw || ms) && !PCSrcE;
            fle = (lw || PCSrcE) && !ms;
            if (!rst) begin
                ms = 0; busy = 0; sfd = 0; fle = 0;
            end
            chk("ForwardAE", i, 32'(fa[i]), rst ? 32'(ref_fwd(Rs1_E)) : 32'd0);
            chk("ForwardBE", i, 32'(fb[i]), rst ? 32'(ref_fwd(Rs2_E)) : 32'd0);
            chk("StallF", i, 32'(sf[i]), 32'(sfd));
            chk("StallD", i, 32'(sd[i]), 32'(sfd));
            chk("StallE", i, 32'(se[i]), 32'(ms));
            chk("FlushM", i, 32'(fm[i]), 32'(ms));
            chk("FlushD", i, 32'(fd[i]), 32'(rst && PCSrcE));
            chk("FlushE", i, 32'(fe[i]), 32'(fle));
            chk("BusyE", i, 32'(be[i]), 32'(busy));
            chk("StallCnt", i, sc[i], m_sc[i]);
            chk("FlushCnt", i, fc[i], m_fc[i]);
            if (rst) chk("branch_while_busy", i, 32'(PCSrcE && be[i]), 32'd0);
            if (i == 0) stall_obs0 += int'(se[0]);
            if (rst) begin
                m_sc[i] = m_sc[i] + 32'(sfd);
                m_fc[i] = m_fc[i] + 32'(fle);
                if (phase[i] == 0) phase[i] = ms ? 1 : 0;
                else phase[i] = (phase[i] + 1 == lat[i]) ? 0 : phase[i] + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W} = '0;
        ResultSrcE = 2'b00;
        {MultiE, PCSrcE, RegWriteM, RegWriteW} = '0;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        cycle();                                   // reset state
        cycle();
        rst = 1'b1;

        // Forwarding: Memory wins over Writeback; x0 never forwarded.
        RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs1_E = 5; Rs2_E = 5;
        cycle();
        chk("fwdA_mem_prio", 0, 32'(fa[0]), 32'd2);
        RD_M = 0; Rs1_E = 0; Rs2_E = 5;
        cycle();
        chk("fwdB_wb", 0, 32'(fb[0]), 32'd1);
        clear_inputs();

        // Load-use, then load-use under a taken branch.
        ResultSrcE = 2'b01; RD_E = 7; Rs2_D = 7;
        cycle();
        clear_inputs();
        cycle();
        chk("lw_stallcnt", 0, sc[0], 32'd1);
        chk("lw_flushcnt", 0, fc[0], 32'd1);
        ResultSrcE = 2'b01; RD_E = 7; Rs2_D = 7; PCSrcE = 1;
        cycle();
        clear_inputs();

        // Multi-cycle op held in Execute: exactly two stall cycles at MUL_LAT=3.
        stall_obs0 = 0;
        MultiE = 1;
        for (int k = 0; k < 3; k++) cycle();
        MultiE = 0;
        cycle();
        chk("mul_stall_cycles", 0, 32'(stall_obs0), 32'd2);

        // Multi-cycle op with a concurrent load-use hazard.
        MultiE = 1; ResultSrcE = 2'b01; RD_E = 3; Rs1_D = 3;
        for (int k = 0; k < 3; k++) cycle();
        clear_inputs();
        cycle();

        // Reset in BUSY with cnt==1, then a fresh op.
        MultiE = 1;
        cycle();
        rst = 1'b0; MultiE = 0;
        cycle();
        rst = 1'b1;
        stall_obs0 = 0;
        MultiE = 1;
        for (int k = 0; k < 3; k++) cycle();
        MultiE = 0;
        cycle();
        chk("mul_after_reset", 0, 32'(stall_obs0), 32'd2);

        // Randomized traffic; never branch while the MUL_LAT=3 instance is busy.
        for (int n = 0; n < 400; n++) begin
            Rs1_D = 5'($urandom_range(0, 3));
            Rs2_D = 5'($urandom_range(0, 3));
            Rs1_E = 5'($urandom_range(0, 3));
            Rs2_E = 5'($urandom_range(0, 3));
            RD_E  = 5'($urandom_range(0, 3));
            RD_M  = 5'($urandom_range(0, 3));
            RD_W  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            MultiE     = ($urandom_range(0, 5) == 0);
            PCSrcE     = ($urandom_range(0, 4) == 0);
            if (phase[0] != 0 || MultiE) PCSrcE = 1'b0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage RISC-V core; supersedes the forwarding-only hazard unit. It generates forwarding selects, detects load-use hazards, flushes on taken branches/jumps, and adds a counter-based stall FSM for multi-cycle execute operations (MUL/DIV). Two free-running performance counters record stall and flush cycles. It sits beside the stage modules in the pipeline top and drives their stall/flush enables.

## Interface
- REG_AW, 5, register-address width
- MUL_LAT, 3, total cycles a multi-cycle op occupies Execute (≥1)
- CNT_W, 32, performance-counter width
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-low
- Rs1_D, Rs2_D  in  REG_AW  source regs of instruction in Decode
- Rs1_E, Rs2_E, RD_E  in  REG_AW  source/dest regs in Execute
- ResultSrcE  in  2  Execute result source; 2'b01 = load
- MultiE  in  1  instruction in Execute is multi-cycle
- PCSrcE  in  1  taken branch/jump resolved in Execute
- RD_M, RegWriteM  in  REG_AW, 1  Memory-stage destination and write enable
- RD_W, RegWriteW  in  REG_AW, 1  Writeback-stage destination and write enable
- ForwardAE, ForwardBE  out  2  operand selects: 00 regfile, 01 ResultW, 10 ALU_ResultM
- StallF, StallD, StallE  out  1  hold PC / IF-ID / ID-EX registers
- FlushD, FlushE, FlushM  out  1  clear IF-ID / ID-EX / EX-MEM registers to bubble
- BusyE  out  1  multi-cycle op in progress
- StallCnt, FlushCnt  out  CNT_W  performance counters

## Operation
- Forwarding, per operand (A uses Rs1_E, B uses Rs2_E): 10 if RegWriteM & RD_M==Rs & Rs!=0; else 01 if RegWriteW & RD_W==Rs & Rs!=0; else 00. Memory has priority over Writeback. x0 is never forwarded.
- Load-use: lwStall = (ResultSrcE==01) & RD_E!=0 & (RD_E==Rs1_D | RD_E==Rs2_D).
- Multi-cycle FSM, states IDLE and BUSY, with a down-counter cnt of width clog2(MUL_LAT).
  - IDLE & MultiE & MUL_LAT>1: mulStall=1; next state BUSY, cnt=MUL_LAT-2.
  - BUSY & cnt!=0: mulStall=1; cnt decrements.
  - BUSY & cnt==0: mulStall=0; next state IDLE. The op leaves Execute on this cycle.
  - MUL_LAT==1: FSM stays in IDLE; no stall.
- BusyE = BUSY | (IDLE & MultiE & MUL_LAT>1).
- Output equations:
  - StallE = FlushM = mulStall.
  - StallF = StallD = (lwStall | mulStall) & ~PCSrcE. A taken branch always lets the PC load its target.
  - FlushD = PCSrcE.
  - FlushE = (lwStall | PCSrcE) & ~mulStall. A held multi-cycle instruction is never killed.
- Counters:
  - StallCnt increments on each cycle with StallF=1.
  - FlushCnt increments on each cycle with FlushE=1.
  - Both wrap modulo 2^CNT_W.
- Simultaneous events:
  - lwStall with mulStall: Decode held, no bubble inserted into Execute.
  - PCSrcE with lwStall: flush wins, no stall.
  - PCSrcE with BusyE is illegal (a multi-cycle op is not a branch); the bench asserts it never occurs.

## Timing
- Forward selects, stalls and flushes are combinational from same-cycle inputs and FSM state; zero-cycle latency.
- FSM state, cnt and counters update on the rising edge of clk.
- A multi-cycle op causes exactly MUL_LAT-1 stall cycles.
- While rst=0 (asynchronous, takes effect immediately):
  - FSM goes to IDLE and cnt=0.
  - StallCnt=FlushCnt=0.
  - All stall, flush, forward and BusyE outputs read 0.
- Reset asserted mid-BUSY abandons the op. After release the FSM starts in IDLE.

## Structure
- Shared package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - RESULT_LOAD=2'b01
  - FSM state encoding IDLE/BUSY
- Sub-module forward_sel (one operand's priority compare), instantiated twice for A and B.
- FSM, hazard equations and counters live in the top.

## Test plan
- RegWriteM=1, RD_M=5, RegWriteW=1, RD_W=5, Rs1_E=5 -> ForwardAE=10. With RD_M=0 and Rs1_E=0 -> ForwardAE=00.
- ResultSrcE=01, RD_E=7, Rs2_D=7 -> one cycle of StallF=StallD=FlushE=1; StallCnt becomes 1, FlushCnt becomes 1.
- Same load-use with PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1.
- MUL_LAT=3, MultiE held high -> StallF/D/E=FlushM=1 for exactly 2 cycles, then 0 and FSM returns to IDLE. Repeat with MUL_LAT=1 -> no stall.
- MultiE with a concurrent load-use hazard -> FlushE stays 0 during both stall cycles.
- Drive rst=0 at cnt=1 in BUSY -> outputs go to 0 immediately, StallCnt=0. After release, a MultiE pulse takes the full MUL_LAT-1 stall cycles again.
